// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// load/store funct3 codes and the access legality check (size/sign code
// versus direction and address alignment).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; halves need an even address,
  // words a word-aligned one.
  function automatic logic lsu_legal(input logic       store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
//  funct3   in  3   size/sign code of the access
//  addr_lo  in  2   byte offset within the word
//  st_data  in  32  rs2 data for stores
//  ld_word  in  32  raw word returned by memory
//  st_be    out 4   byte enables for a store
//  st_wdata out 32  store data replicated onto every lane
//  ld_data  out 32  extracted and sign/zero-extended load data
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_sh = ld_word >> {addr_lo, 3'b000};
  assign half_sh = ld_word >> {addr_lo[1], 4'b0000};
  assign ld_byte = byte_sh[7:0];
  assign ld_half = half_sh[15:0];

  // Replicating the data lets memory pick whichever lane the enables select.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: accepts one load/store from the core,
// drives a handshaked word-wide memory and returns a one-cycle response.
//  clk, rst                clock; synchronous active-low reset
//  req_valid/req_ready     request handshake from the core
//  req_store/req_funct3    direction and size/sign code
//  req_addr/req_wdata      byte address and rs2 store data
//  resp_valid/rdata/err    one-cycle completion pulse, load data, error flag
//  mem_req/we/be/addr/wdata  memory request, held until mem_gnt
//  mem_gnt/rvalid/rdata    memory grant and read-data return
module load_store_unit import lsu_pkg::*; #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic              unused_addr_hi;

  // Address bits above the memory window simply wrap.
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  // One aligner serves both directions: live request fields while idle
  // (store steering), latched fields while waiting for read data.
  assign al_f3 = (state_q == IDLE) ? req_funct3    : f3_q;
  assign al_lo = (state_q == IDLE) ? req_addr[1:0] : alo_q;

  lsu_align u_align (
    .funct3   (al_f3),
    .addr_lo  (al_lo),
    .st_data  (req_wdata),
    .ld_word  (mem_rdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    f3_d         = f3_q;
    alo_d        = alo_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          store_d     = req_store;
          f3_d        = req_funct3;
          alo_d       = req_addr[1:0];
          req_ready_d = 1'b0;
          if (lsu_legal(req_store, req_funct3, req_addr[1:0])) begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_be_d    = req_store ? st_be : 4'b1111;
            mem_addr_d  = req_addr[ADDR_W-1:2];
            mem_wdata_d = req_store ? st_wdata : 32'h0;
          end else begin
            // Illegal accesses never touch memory.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (store_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // rvalid is checked first so it wins over a simultaneous timeout.
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Access attributes are only consulted after being loaded on accept.
  always_ff @(posedge clk) begin
    store_q <= store_d;
    f3_q    <= f3_d;
    alo_q   <= alo_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
